// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator.
// Function codes and FSM states.
package calc_pkg;

    typedef enum logic [1:0] {
        FCT_ADD = 2'b00,
        FCT_SUB = 2'b01,
        FCT_MUL = 2'b10,
        FCT_DIV = 2'b11
    } fct_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_calc_muldiv_iter.sv
// Iterative shift-add multiply / restoring divide datapath.
// res/rem present the value after the current step completes.
module muldiv_iter
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               step,
    input  fct_e               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] res,
    output logic [2*WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   part;
    logic [WIDTH-1:0]   dvsr;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   part_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               is_div;

    assign is_div = (mode == FCT_DIV);
    assign last   = (cnt == CW'(WIDTH - 1));

    // One iteration of each algorithm; bit WIDTH of diff is the borrow.
    always_comb begin
        acc_nxt = mplier[0] ? acc + mcand : acc;
        trial   = {part, quo[WIDTH-1]};
        diff    = trial - {1'b0, dvsr};
        if (diff[WIDTH]) begin
            part_nxt = trial[WIDTH-1:0];
            quo_nxt  = {quo[WIDTH-2:0], 1'b0};
        end else begin
            part_nxt = diff[WIDTH-1:0];
            quo_nxt  = {quo[WIDTH-2:0], 1'b1};
        end
        if (is_div) begin
            res = {{WIDTH{1'b0}}, quo_nxt};
            rem = {{WIDTH{1'b0}}, part_nxt};
        end else begin
            res = acc_nxt;
            rem = '0;
        end
    end

    // Load operands on init, advance one iteration per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            quo    <= '0;
            part   <= '0;
            dvsr   <= '0;
        end else if (init) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            quo    <= a;
            part   <= '0;
            dvsr   <= b;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                quo  <= quo_nxt;
                part <= part_nxt;
            end else begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

endmodule

// File: rtl/seq_calc.sv
// Handshaked multi-cycle calculator: add, sub, mul, div.
// FSM, add/sub, zero-divisor check and result registers.
module seq_calc
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         fct_i,
    output logic [2*WIDTH-1:0] res_o,
    output logic [2*WIDTH-1:0] rem_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    state_e             state;
    state_e             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    fct_e               fct_q;

    logic               accept;
    logic               iter;
    logic               finish;
    logic               it_last;
    logic [2*WIDTH-1:0] it_res;
    logic [2*WIDTH-1:0] it_rem;
    logic [2*WIDTH-1:0] res_nxt;
    logic [2*WIDTH-1:0] rem_nxt;
    logic               err_nxt;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk  (clock_i),
        .rst  (reset_i),
        .init (accept),
        .step (iter),
        .mode (fct_q),
        .a    (a_i),
        .b    (b_i),
        .last (it_last),
        .res  (it_res),
        .rem  (it_rem)
    );

    assign busy_o = (state == ST_EXEC);
    assign done_o = (state == ST_DONE);

    // State register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next state, iteration control and completion values.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        iter      = 1'b0;
        finish    = 1'b0;
        res_nxt   = res_o;
        rem_nxt   = rem_o;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                unique case (fct_q)
                    FCT_ADD: begin
                        finish  = 1'b1;
                        res_nxt = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
                        rem_nxt = '0;
                    end
                    FCT_SUB: begin
                        finish  = 1'b1;
                        res_nxt = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
                        rem_nxt = '0;
                    end
                    FCT_MUL: begin
                        iter    = 1'b1;
                        finish  = it_last;
                        res_nxt = it_res;
                        rem_nxt = '0;
                    end
                    FCT_DIV: begin
                        if (b_q == '0) begin
                            finish  = 1'b1;
                            res_nxt = '1;
                            rem_nxt = {{WIDTH{1'b0}}, a_q};
                            err_nxt = 1'b1;
                        end else begin
                            iter    = 1'b1;
                            finish  = it_last;
                            res_nxt = it_res;
                            rem_nxt = it_rem;
                        end
                    end
                endcase
                if (finish) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture operands on accept; update outputs on completion.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            a_q   <= '0;
            b_q   <= '0;
            fct_q <= FCT_ADD;
            res_o <= '0;
            rem_o <= '0;
            err_o <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= a_i;
                b_q   <= b_i;
                fct_q <= fct_e'(fct_i);
            end
            if (finish) begin
                res_o <= res_nxt;
                rem_o <= rem_nxt;
                err_o <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_calc.sv
// Directed self-checking bench for seq_calc (WIDTH=8).
// Outputs are sampled on the falling clock edge.
module tb_seq_calc;

    localparam int W = 8;

    logic           clock_i = 1'b0;
    logic           reset_i = 1'b0;
    logic           start_i = 1'b0;
    logic [W-1:0]   a_i     = '0;
    logic [W-1:0]   b_i     = '0;
    logic [1:0]     fct_i   = 2'b00;
    logic [2*W-1:0] res_o;
    logic [2*W-1:0] rem_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;

    int checks   = 0;
    int failures = 0;
    int busy_n;
    int found;
    int both;
    int done_n;
    logic [2*W-1:0] held;

    seq_calc #(.WIDTH(W)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .fct_i   (fct_i),
        .res_o   (res_o),
        .rem_o   (rem_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done_o.
    // disturb: scramble inputs and pulse start_i while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] f, input bit disturb,
                          output int nbusy, output int ok, output int nboth);
        @(negedge clock_i);
        a_i = a; b_i = b; fct_i = f; start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        nbusy = 0; ok = 0; nboth = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o && done_o) nboth++;
            if (done_o) begin
                ok = 1;
                start_i = 1'b0;
                break;
            end
            if (busy_o) nbusy++;
            if (disturb) begin
                a_i = W'($urandom);
                b_i = W'($urandom);
                fct_i = 2'(i);
                start_i = ~start_i;
            end
            @(negedge clock_i);
        end
    endtask

    initial begin
        // Reset state
        reset_i = 1'b1;
        #12;
        check("rst_res", 32'(res_o), 32'h0);
        check("rst_rem", 32'(rem_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // Add 200+100
        run_op(8'd200, 8'd100, 2'b00, 1'b0, busy_n, found, both);
        check("add_done", 32'(found), 32'd1);
        check("add_busy", 32'(busy_n), 32'd1);
        check("add_res", 32'(res_o), 32'h012C);
        check("add_rem", 32'(rem_o), 32'h0);
        check("add_err", 32'(err_o), 32'h0);

        // Sub 5-7
        run_op(8'd5, 8'd7, 2'b01, 1'b0, busy_n, found, both);
        check("sub_done", 32'(found), 32'd1);
        check("sub_busy", 32'(busy_n), 32'd1);
        check("sub_res", 32'(res_o), 32'hFFFE);
        check("sub_err", 32'(err_o), 32'h0);
        @(negedge clock_i);
        check("sub_done_w", 32'(done_o), 32'h0);
        check("sub_busy_after", 32'(busy_o), 32'h0);

        // Mul 255*255 with inputs disturbed while busy
        run_op(8'd255, 8'd255, 2'b10, 1'b1, busy_n, found, both);
        check("mul_done", 32'(found), 32'd1);
        check("mul_busy", 32'(busy_n), 32'd8);
        check("mul_both", 32'(both), 32'd0);
        check("mul_res", 32'(res_o), 32'hFE01);
        check("mul_rem", 32'(rem_o), 32'h0);
        held = res_o;
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock_i);
            if (busy_o || done_o) busy_n++;
        end
        check("mul_no_second", 32'(busy_n), 32'd0);
        check("mul_hold", 32'(res_o), 32'(held));

        // Div 200/7
        run_op(8'd200, 8'd7, 2'b11, 1'b0, busy_n, found, both);
        check("div_done", 32'(found), 32'd1);
        check("div_busy", 32'(busy_n), 32'd8);
        check("div_res", 32'(res_o), 32'd28);
        check("div_rem", 32'(rem_o), 32'd4);
        check("div_err", 32'(err_o), 32'h0);

        // Div 0/3
        run_op(8'd0, 8'd3, 2'b11, 1'b0, busy_n, found, both);
        check("div0n_done", 32'(found), 32'd1);
        check("div0n_res", 32'(res_o), 32'd0);
        check("div0n_rem", 32'(rem_o), 32'd0);

        // Divide by zero
        run_op(8'h5A, 8'd0, 2'b11, 1'b0, busy_n, found, both);
        check("dbz_done", 32'(found), 32'd1);
        check("dbz_busy", 32'(busy_n), 32'd1);
        check("dbz_res", 32'(res_o), 32'hFFFF);
        check("dbz_rem", 32'(rem_o), 32'h005A);
        check("dbz_err", 32'(err_o), 32'h1);

        // Add 1+1 clears error
        run_op(8'd1, 8'd1, 2'b00, 1'b0, busy_n, found, both);
        check("add2_res", 32'(res_o), 32'd2);
        check("add2_rem", 32'(rem_o), 32'd0);
        check("add2_err", 32'(err_o), 32'h0);

        // Reset during the 4th EXEC cycle of a multiply
        @(negedge clock_i);
        a_i = 8'd9; b_i = 8'd9; fct_i = 2'b10; start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (3) @(negedge clock_i);
        check("rm_busy_pre", 32'(busy_o), 32'h1);
        reset_i = 1'b1;
        #1;
        check("rm_res", 32'(res_o), 32'h0);
        check("rm_rem", 32'(rem_o), 32'h0);
        check("rm_err", 32'(err_o), 32'h0);
        check("rm_busy", 32'(busy_o), 32'h0);
        done_n = 0;
        repeat (2) begin
            @(negedge clock_i);
            if (done_o) done_n++;
        end
        reset_i = 1'b0;
        repeat (10) begin
            @(negedge clock_i);
            if (done_o || busy_o) done_n++;
        end
        check("rm_no_done", 32'(done_n), 32'd0);

        // Mul 3*4 after reset
        run_op(8'd3, 8'd4, 2'b10, 1'b0, busy_n, found, both);
        check("mul2_done", 32'(found), 32'd1);
        check("mul2_res", 32'(res_o), 32'd12);
        check("mul2_err", 32'(err_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
